// File: rtl/axi4lite_manager_pkg.sv
// axi4lite_manager_pkg: response codes and FSM state encoding shared by the AXI4-Lite manager files
package axi4lite_manager_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_RSP} state_t;
endpackage

// File: rtl/axi4lite_manager_watchdog.sv
// axi4lite_manager_watchdog: transaction watchdog; expired fires in the TIMEOUT-th enabled cycle after clr
// so the abort registered on that edge leaves exactly TIMEOUT cycles of valid/ready activity.
module axi4lite_manager_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [CW-1:0] cnt;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) cnt <= '0;
        else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
    end
    assign expired = (TIMEOUT != 0) && en && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/axi4lite_manager.sv
// axi4lite_manager: single-outstanding AXI4-Lite manager bridging a valid/ready command port to AXI reads/writes
// with a watchdog that abandons transactions to unresponsive subordinates.
module axi4lite_manager
    import axi4lite_manager_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] m_axi_lite_awaddr,
    output logic [2:0]        m_axi_lite_awprot,
    output logic              m_axi_lite_awvalid,
    input  logic              m_axi_lite_awready,
    output logic [31:0]       m_axi_lite_wdata,
    output logic [3:0]        m_axi_lite_wstrb,
    output logic              m_axi_lite_wvalid,
    input  logic              m_axi_lite_wready,
    input  logic [1:0]        m_axi_lite_bresp,
    input  logic              m_axi_lite_bvalid,
    output logic              m_axi_lite_bready,
    output logic [ADDR_W-1:0] m_axi_lite_araddr,
    output logic [2:0]        m_axi_lite_arprot,
    output logic              m_axi_lite_arvalid,
    input  logic              m_axi_lite_arready,
    input  logic [31:0]       m_axi_lite_rdata,
    input  logic [1:0]        m_axi_lite_rresp,
    input  logic              m_axi_lite_rvalid,
    output logic              m_axi_lite_rready
);
    state_t state;
    logic busy, done, expired;
    assign m_axi_lite_awprot = 3'b000;
    assign m_axi_lite_arprot = 3'b000;
    assign busy = state inside {S_WRITE, S_WRESP, S_READ, S_RDATA};
    // done marks the handshake that completes the current state; it beats a same-cycle expiry
    always_comb begin
        done = (state == S_WRITE) ? (!m_axi_lite_awvalid || m_axi_lite_awready) && (!m_axi_lite_wvalid || m_axi_lite_wready) :
               (state == S_WRESP) ? m_axi_lite_bvalid :
               (state == S_READ)  ? m_axi_lite_arready :
               (state == S_RDATA) ? m_axi_lite_rvalid : 1'b0;
    end
    axi4lite_manager_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr     (state == S_IDLE),
        .en      (busy),
        .expired (expired)
    );
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= S_IDLE;
            cmd_ready          <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_rdata          <= '0;
            rsp_resp           <= RESP_OKAY;
            rsp_timeout        <= 1'b0;
            m_axi_lite_awaddr  <= '0;
            m_axi_lite_awvalid <= 1'b0;
            m_axi_lite_wdata   <= '0;
            m_axi_lite_wstrb   <= '0;
            m_axi_lite_wvalid  <= 1'b0;
            m_axi_lite_bready  <= 1'b0;
            m_axi_lite_araddr  <= '0;
            m_axi_lite_arvalid <= 1'b0;
            m_axi_lite_rready  <= 1'b0;
        end else if (expired && !done) begin
            m_axi_lite_awvalid <= 1'b0;
            m_axi_lite_wvalid  <= 1'b0;
            m_axi_lite_bready  <= 1'b0;
            m_axi_lite_arvalid <= 1'b0;
            m_axi_lite_rready  <= 1'b0;
            rsp_valid          <= 1'b1;
            rsp_rdata          <= '0;
            rsp_resp           <= RESP_SLVERR;
            rsp_timeout        <= 1'b1;
            state              <= S_RSP;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready         <= 1'b0;
                        m_axi_lite_bready <= 1'b0;
                        m_axi_lite_rready <= 1'b0;
                        if (cmd_write) begin
                            m_axi_lite_awaddr  <= cmd_addr;
                            m_axi_lite_wdata   <= cmd_wdata;
                            m_axi_lite_wstrb   <= cmd_wstrb;
                            m_axi_lite_awvalid <= 1'b1;
                            m_axi_lite_wvalid  <= 1'b1;
                            state              <= S_WRITE;
                        end else begin
                            m_axi_lite_araddr  <= cmd_addr;
                            m_axi_lite_arvalid <= 1'b1;
                            state              <= S_READ;
                        end
                    end else begin
                        cmd_ready         <= 1'b1;
                        m_axi_lite_bready <= 1'b1;
                        m_axi_lite_rready <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (m_axi_lite_awready) m_axi_lite_awvalid <= 1'b0;
                    if (m_axi_lite_wready) m_axi_lite_wvalid <= 1'b0;
                    if (done) begin
                        m_axi_lite_bready <= 1'b1;
                        state             <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (m_axi_lite_bvalid) begin
                        m_axi_lite_bready <= 1'b0;
                        rsp_valid         <= 1'b1;
                        rsp_rdata         <= '0;
                        rsp_resp          <= m_axi_lite_bresp;
                        rsp_timeout       <= 1'b0;
                        state             <= S_RSP;
                    end
                end
                S_READ: begin
                    if (m_axi_lite_arready) begin
                        m_axi_lite_arvalid <= 1'b0;
                        m_axi_lite_rready  <= 1'b1;
                        state              <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m_axi_lite_rvalid) begin
                        m_axi_lite_rready <= 1'b0;
                        rsp_valid         <= 1'b1;
                        rsp_rdata         <= m_axi_lite_rdata;
                        rsp_resp          <= m_axi_lite_rresp;
                        rsp_timeout       <= 1'b0;
                        state             <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid         <= 1'b0;
                        cmd_ready         <= 1'b1;
                        m_axi_lite_bready <= 1'b1;
                        m_axi_lite_rready <= 1'b1;
                        state             <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4lite_manager.sv
// tb_axi4lite_manager: randomized bench with a behavioural memory subordinate and a command-level reference memory
`timescale 1ns/1ps
module tb_axi4lite_manager;
    localparam int TO = 16;
    logic aclk = 1'b0, aresetn = 1'b1;
    always #5 aclk = ~aclk;

    logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0] cmd_wstrb = '0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0] awprot, arprot;
    logic [3:0] wstrb;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0] bresp, rresp;

    axi4lite_manager #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .m_axi_lite_awaddr(awaddr), .m_axi_lite_awprot(awprot), .m_axi_lite_awvalid(awvalid),
        .m_axi_lite_awready(awready),
        .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb), .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
        .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
        .m_axi_lite_araddr(araddr), .m_axi_lite_arprot(arprot), .m_axi_lite_arvalid(arvalid),
        .m_axi_lite_arready(arready),
        .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready)
    );

    int checks = 0, errors = 0;
    int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    bit inject_b = 1'b0;
    logic [31:0] sub_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic bit mapped(input logic [31:0] a);
        return a < 32'h200;
    endfunction

    // Command-level reference: byte-strobed word memory below 0x200, SLVERR and zero data above
    function automatic void model(input bit wr, input logic [31:0] a, d, input logic [3:0] s,
                                  output logic [31:0] rd, output logic [1:0] rr);
        logic [31:0] v;
        rd = '0;
        rr = mapped(a) ? 2'b00 : 2'b10;
        if (mapped(a)) begin
            v = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
            if (wr) begin
                for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
                ref_mem[a] = v;
            end else rd = v;
        end
    endfunction

    // Handshake monitor, sampled on the active edge before the DUT updates
    bit aw_seen, w_seen, ar_seen, b_ack, r_ack;
    logic [31:0] aw_a, w_d, ar_a, p_awaddr, p_wdata, p_araddr;
    logic [3:0] w_s, p_wstrb;
    bit p_aw, p_w, p_ar;
    int b_hs = 0, prot_err = 0;
    always @(posedge aclk) begin
        if (!aresetn) begin
            p_aw = 0; p_w = 0; p_ar = 0;
        end else begin
            if (p_aw && awvalid && awaddr !== p_awaddr) prot_err++;
            if (p_w && wvalid && (wdata !== p_wdata || wstrb !== p_wstrb)) prot_err++;
            if (p_ar && arvalid && araddr !== p_araddr) prot_err++;
            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w = wvalid && !wready; p_wdata = wdata; p_wstrb = wstrb;
            p_ar = arvalid && !arready; p_araddr = araddr;
            if (awvalid && awready) begin aw_seen = 1; aw_a = awaddr; end
            if (wvalid && wready) begin w_seen = 1; w_d = wdata; w_s = wstrb; end
            if (arvalid && arready) begin ar_seen = 1; ar_a = araddr; end
            if (bvalid && bready) begin b_ack = 1; b_hs++; end
            if (rvalid && rready) r_ack = 1;
        end
    end

    // Subordinate: per-channel ready delays, responses one cycle (plus b/r delay) after the request
    initial begin : subordinate
        int aw_c, w_c, ar_c, b_c, r_c;
        bit b_pend, r_pend;
        logic [1:0] b_q, r_q;
        logic [31:0] rd_q, v;
        {awready, wready, arready, bvalid, rvalid} = '0;
        bresp = '0; rresp = '0; rdata = '0;
        {aw_c, w_c, ar_c, b_c, r_c} = '0; {b_pend, r_pend} = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                {awready, wready, arready, bvalid, rvalid} = '0;
                {aw_seen, w_seen, ar_seen, b_ack, r_ack, b_pend, r_pend} = '0;
                {aw_c, w_c, ar_c} = '0;
            end else begin
                if (aw_seen && w_seen) begin
                    if (mapped(aw_a)) begin
                        v = sub_mem.exists(aw_a) ? sub_mem[aw_a] : 32'h0;
                        for (int i = 0; i < 4; i++) if (w_s[i]) v[8*i +: 8] = w_d[8*i +: 8];
                        sub_mem[aw_a] = v;
                    end
                    b_q = mapped(aw_a) ? 2'b00 : 2'b10;
                    b_pend = 1; b_c = 0; aw_seen = 0; w_seen = 0;
                end
                if (ar_seen) begin
                    rd_q = (mapped(ar_a) && sub_mem.exists(ar_a)) ? sub_mem[ar_a] : 32'h0;
                    r_q = mapped(ar_a) ? 2'b00 : 2'b10;
                    r_pend = 1; r_c = 0; ar_seen = 0;
                end
                if (b_ack) begin bvalid = 0; b_ack = 0; end
                if (r_ack) begin rvalid = 0; r_ack = 0; end
                if (b_pend) begin
                    if (b_c >= b_delay) begin bvalid = 1; bresp = b_q; b_pend = 0; end else b_c++;
                end
                if (r_pend) begin
                    if (r_c >= r_delay) begin rvalid = 1; rresp = r_q; rdata = rd_q; r_pend = 0; end else r_c++;
                end
                if (inject_b) begin bvalid = 1; bresp = 2'b00; inject_b = 0; end
                if (!awvalid) aw_c = 0;
                awready = awvalid && aw_c >= aw_delay;
                if (awvalid) aw_c++;
                if (!wvalid) w_c = 0;
                wready = wvalid && w_c >= w_delay;
                if (wvalid) w_c++;
                if (!arvalid) ar_c = 0;
                arready = arvalid && ar_c >= ar_delay;
                if (arvalid) ar_c++;
            end
        end
    end

    // Returns at the falling edge of cycle N+1, N being the accept cycle
    task automatic send_cmd(input bit wr, input logic [31:0] a, d, input logic [3:0] s);
        int t = 0;
        @(negedge aclk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && t < 50) begin @(negedge aclk); t++; end
        checks++;
        if (t >= 50) begin errors++; $display("FAIL cmd_accept: cmd_ready stayed %b, required 1", cmd_ready); end
        @(negedge aclk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(output int k, output logic [31:0] rd, output logic [1:0] rr, output logic to);
        k = 1;
        while (!rsp_valid && k < 200) begin @(negedge aclk); k++; end
        if (!rsp_valid) k = -1;
        rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
    endtask

    task automatic take_rsp;
        rsp_ready = 1;
        @(negedge aclk);
        rsp_ready = 0;
    endtask

    task automatic test_reset;
        #1 aresetn = 0;
        repeat (3) @(negedge aclk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_timeout, awvalid, wvalid, bready, arvalid, rready} !== 8'h00) begin
            errors++; $display("FAIL reset_ctl: got %b, required 00000000",
                {cmd_ready, rsp_valid, rsp_timeout, awvalid, wvalid, bready, arvalid, rready});
        end
        checks++;
        if ({rsp_resp, rsp_rdata, awaddr, wdata, wstrb, araddr} !== '0) begin
            errors++; $display("FAIL reset_data: resp=%b rdata=%h awaddr=%h wdata=%h wstrb=%h araddr=%h, required all 0",
                rsp_resp, rsp_rdata, awaddr, wdata, wstrb, araddr);
        end
        #2 aresetn = 1;
        @(negedge aclk);
        checks++;
        if ({cmd_ready, bready, rready} !== 3'b111) begin
            errors++; $display("FAIL reset_release: cmd_ready/bready/rready=%b, required 111", {cmd_ready, bready, rready});
        end
    endtask

    task automatic test_write_zero_wait;
        logic [31:0] rd, erd; logic [1:0] rr, err; logic to; int k;
        model(1, 32'h104, 32'h10, 4'hF, erd, err);
        send_cmd(1, 32'h104, 32'h10, 4'hF);
        checks++;
        if ({awvalid, wvalid} !== 2'b11 || awaddr !== 32'h104 || wdata !== 32'h10 || wstrb !== 4'hF || awprot !== 3'b000) begin
            errors++; $display("FAIL zw_issue: aw/wvalid=%b awaddr=%h wdata=%h wstrb=%h awprot=%b, required 11 104 10 f 000",
                {awvalid, wvalid}, awaddr, wdata, wstrb, awprot);
        end
        wait_rsp(k, rd, rr, to);
        checks++;
        if (k !== 3) begin errors++; $display("FAIL zw_latency: rsp_valid at N+%0d, required N+3", k); end
        checks++;
        if (rr !== err || rd !== erd || to !== 1'b0) begin
            errors++; $display("FAIL zw_rsp: resp=%b rdata=%h to=%b, required %b %h 0", rr, rd, to, err, erd);
        end
        take_rsp;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zw_cmd_ready: got %b at N+4, required 1", cmd_ready); end
    endtask

    task automatic test_aw_delay;
        logic [31:0] rd, erd, d; logic [1:0] rr, err; logic to; int k, b0;
        d = $urandom;
        aw_delay = 3;
        b0 = b_hs;
        model(1, 32'h108, d, 4'hF, erd, err);
        send_cmd(1, 32'h108, d, 4'hF);
        @(negedge aclk);
        checks++;
        if ({awvalid, wvalid} !== 2'b10) begin
            errors++; $display("FAIL awdly_channels: aw/wvalid=%b at N+2, required 10", {awvalid, wvalid});
        end
        wait_rsp(k, rd, rr, to);
        checks++;
        if (k < 0 || rr !== err || to !== 1'b0) begin
            errors++; $display("FAIL awdly_rsp: k=%0d resp=%b to=%b, required resp %b to 0", k, rr, to, err);
        end
        take_rsp;
        checks++;
        if (b_hs - b0 !== 1) begin errors++; $display("FAIL awdly_bcount: %0d B handshakes, required 1", b_hs - b0); end
        aw_delay = 0;
    endtask

    task automatic test_read_delay;
        logic [31:0] rd, erd; logic [1:0] rr, err; logic to; int k;
        model(1, 32'h100, 32'h3, 4'hF, erd, err);
        send_cmd(1, 32'h100, 32'h3, 4'hF);
        wait_rsp(k, rd, rr, to);
        take_rsp;
        ar_delay = 5;
        model(0, 32'h100, 32'h0, 4'h0, erd, err);
        send_cmd(0, 32'h100, 32'h0, 4'h0);
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h100 || arprot !== 3'b000) begin
            errors++; $display("FAIL rdly_issue: arvalid=%b araddr=%h arprot=%b, required 1 100 000", arvalid, araddr, arprot);
        end
        wait_rsp(k, rd, rr, to);
        checks++;
        if (k < 0 || rd !== erd || rr !== err || to !== 1'b0) begin
            errors++; $display("FAIL rdly_rsp: k=%0d rdata=%h resp=%b to=%b, required %h %b 0", k, rd, rr, to, erd, err);
        end
        take_rsp;
        ar_delay = 0;
    endtask

    task automatic test_read_unmapped;
        logic [31:0] rd, erd; logic [1:0] rr, err; logic to; int k;
        model(0, 32'h200, 32'h0, 4'h0, erd, err);
        send_cmd(0, 32'h200, 32'h0, 4'h0);
        wait_rsp(k, rd, rr, to);
        checks++;
        if (k < 0 || rr !== err || rd !== erd || to !== 1'b0) begin
            errors++; $display("FAIL unmapped_rsp: k=%0d resp=%b rdata=%h to=%b, required %b %h 0", k, rr, rd, to, err, erd);
        end
        take_rsp;
    endtask

    task automatic test_timeout;
        logic [31:0] rd; logic [1:0] rr; logic to; int k, n, b0; bit bad;
        aw_delay = 1000; w_delay = 1000;
        send_cmd(1, 32'h10, 32'hA5A5_5A5A, 4'hF);
        n = 0;
        while (awvalid && n < 100) begin n++; @(negedge aclk); end
        checks++;
        if (n !== TO || wvalid !== 1'b0 || bready !== 1'b0) begin
            errors++; $display("FAIL to_drop: awvalid high %0d cycles wvalid=%b bready=%b, required %0d 0 0", n, wvalid, bready, TO);
        end
        wait_rsp(k, rd, rr, to);
        checks++;
        if (k !== 1 || rr !== 2'b10 || to !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL to_rsp: k=%0d resp=%b to=%b rdata=%h, required 1 10 1 0", k, rr, to, rd);
        end
        aw_delay = 0; w_delay = 0;
        take_rsp;
        b0 = b_hs;
        inject_b = 1;
        bad = 0;
        repeat (5) begin @(negedge aclk); if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad = 1; end
        checks++;
        if (bad || b_hs - b0 !== 1) begin
            errors++; $display("FAIL to_stray_b: spurious rsp or cmd_ready drop=%b, drained %0d, required 0 and 1", bad, b_hs - b0);
        end
    endtask

    task automatic test_timeout_edge;
        logic [31:0] rd, erd, d; logic [1:0] rr, err; logic to; int k;
        d = $urandom;
        aw_delay = TO - 1; w_delay = TO - 1;
        model(1, 32'h14, d, 4'hF, erd, err);
        send_cmd(1, 32'h14, d, 4'hF);
        wait_rsp(k, rd, rr, to);
        checks++;
        if (k < 0 || rr !== err || to !== 1'b0) begin
            errors++; $display("FAIL to_edge: k=%0d resp=%b to=%b, required resp %b to 0", k, rr, to, err);
        end
        take_rsp;
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_rsp_hold;
        logic [31:0] a, rd, erd; logic [1:0] rr, err; logic to; int k; bit bad;
        a = 32'($urandom_range(0, 3)) << 2;
        model(0, a, 32'h0, 4'h0, erd, err);
        send_cmd(0, a, 32'h0, 4'h0);
        wait_rsp(k, rd, rr, to);
        bad = 0;
        repeat (4) begin
            @(negedge aclk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rr || rsp_timeout !== to || cmd_ready !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL hold_stable: rsp fields moved or cmd_ready rose while rsp_ready=0"); end
        checks++;
        if (k < 0 || rd !== erd || rr !== err) begin
            errors++; $display("FAIL hold_rsp: rdata=%h resp=%b, required %h %b", rd, rr, erd, err);
        end
        take_rsp;
    endtask

    task automatic test_reset_wresp;
        int t = 0; bit bad = 0;
        b_delay = 20;
        send_cmd(1, 32'h300, 32'h1234_5678, 4'hF);
        while (!bready && t < 20) begin @(negedge aclk); t++; end
        checks++;
        if (bready !== 1'b1) begin errors++; $display("FAIL rst_wresp_reach: bready=%b, required 1", bready); end
        #2 aresetn = 0;
        #1;
        checks++;
        if ({rsp_valid, awvalid, wvalid, arvalid, bready, rready, cmd_ready} !== 7'b0) begin
            errors++; $display("FAIL rst_wresp_outputs: got %b, required 0000000",
                {rsp_valid, awvalid, wvalid, arvalid, bready, rready, cmd_ready});
        end
        @(negedge aclk);
        #2 aresetn = 1;
        b_delay = 0;
        @(negedge aclk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_wresp_ready: cmd_ready=%b, required 1", cmd_ready); end
        repeat (4) begin @(negedge aclk); if (rsp_valid !== 1'b0) bad = 1; end
        checks++;
        if (bad) begin errors++; $display("FAIL rst_wresp_norsp: response emitted for a lost transaction"); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, d, rd, erd; logic [1:0] rr, err; logic to; int k; bit wr;
        for (int i = 0; i < 6; i++) begin
            wr = (i % 2) == 0;
            a = 32'(i / 2) << 2;
            d = $urandom;
            model(wr, a, d, 4'hF, erd, err);
            send_cmd(wr, a, d, 4'hF);
            wait_rsp(k, rd, rr, to);
            checks++;
            if (k !== 3 || rd !== erd || rr !== err || to !== 1'b0) begin
                errors++; $display("FAIL b2b[%0d]: k=%0d rdata=%h resp=%b to=%b, required 3 %h %b 0", i, k, rd, rr, to, erd, err);
            end
            take_rsp;
        end
    endtask

    task automatic test_random;
        logic [31:0] a, d, rd, erd; logic [1:0] rr, err; logic to; logic [3:0] s; int k; bit wr;
        for (int i = 0; i < 40; i++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            b_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
            wr = $urandom_range(0, 1);
            a = 32'($urandom_range(0, 11)) << 2;
            if ($urandom_range(0, 7) == 0) a = a + 32'h200;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            model(wr, a, d, s, erd, err);
            send_cmd(wr, a, d, s);
            wait_rsp(k, rd, rr, to);
            checks++;
            if (k < 0 || rd !== erd || rr !== err || to !== 1'b0) begin
                errors++; $display("FAIL random[%0d] wr=%b addr=%h: k=%0d rdata=%h resp=%b to=%b, required %h %b 0",
                    i, wr, a, k, rd, rr, to, erd, err);
            end
            take_rsp;
        end
        {aw_delay, w_delay, ar_delay, b_delay, r_delay} = '0;
    endtask

    task automatic test_protocol;
        checks++;
        if (prot_err !== 0) begin errors++; $display("FAIL payload_stable: %0d changes while valid, required 0", prot_err); end
    endtask

    initial begin
        test_reset;
        test_write_zero_wait;
        test_aw_delay;
        test_read_delay;
        test_read_unmapped;
        test_timeout;
        test_timeout_edge;
        test_rsp_hold;
        test_reset_wresp;
        test_back_to_back;
        test_random;
        test_protocol;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end
endmodule
